// File: rtl/uart_rx_engine_if.sv
// Receive holding-register handshake between the UART receive engine and the
// APB register block. The engine presents a byte with rx_valid. The register
// block pulses rx_ack when RX_DATA is read.
interface uart_rx_engine_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;

  // Engine side: produces the byte, consumes the read acknowledge
  modport master (output rx_data, output rx_valid, input rx_ack);
  // Register-block side: consumes the byte, produces the read acknowledge
  modport slave  (input rx_data, input rx_valid, output rx_ack);
endinterface

// File: rtl/uart_rx_engine.sv
// UART receive engine: 16x oversampling 8N1 deframer.
// - A 2-flop synchronizer feeds the FSM.
// - Each bit is decided by a majority vote over oversample ticks 7, 8 and 9.
// - Completed bytes go to a valid/ack holding register.
// - Framing-error and overrun flags are sticky.
module uart_rx_engine #(
  parameter int DIV_WIDTH = 16,
  parameter int OS_RATE   = 16
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic                 rx_en,
  input  logic                 rx_rst,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic                 rx_serial,
  input  logic                 err_clr,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 overrun,
  uart_rx_engine_if.master     rx_if
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  localparam logic [3:0]           OS_LAST  = 4'(OS_RATE - 1);
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO = {DIV_WIDTH{1'b0}};
  localparam logic [DIV_WIDTH-1:0] DIV_ONE  = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

  // Registers
  logic [1:0]           sync_q;
  logic                 rxs_prev_q;
  state_e               state_q,    state_d;
  logic [DIV_WIDTH-1:0] tick_cnt_q, tick_cnt_d;
  logic [DIV_WIDTH-1:0] div_q,      div_d;
  logic [3:0]           os_cnt_q,   os_cnt_d;
  logic [2:0]           bit_idx_q,  bit_idx_d;
  logic [1:0]           samp_q,     samp_d;
  logic [7:0]           shift_q,    shift_d;
  logic [7:0]           data_q,     data_d;
  logic                 valid_q,    valid_d;
  logic                 busy_q,     busy_d;
  logic                 ferr_q,     ferr_d;
  logic                 ovr_q,      ovr_d;

  // Combinational helpers
  logic                 rxs_s;
  logic                 fall_s;
  logic                 active_s;
  logic                 tick_s;
  logic                 maj_s;
  logic                 resolve_s;
  state_e               state_nxt_s;
  logic [DIV_WIDTH-1:0] tick_nxt_s;
  logic [3:0]           os_nxt_s;
  logic                 stop_ok_s;
  logic                 stop_bad_s;
  logic                 stop_ok_g_s;
  logic                 stop_bad_g_s;

  assign rxs_s     = sync_q[1];
  assign fall_s    = rxs_prev_q & ~rxs_s;
  assign active_s  = (state_q != ST_IDLE);
  assign tick_s    = active_s && (tick_cnt_q == div_q);
  // Majority of the samples taken at ticks 7 and 8 plus the live sample at tick 9
  assign maj_s     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs_s) | (samp_q[1] & rxs_s);
  assign resolve_s = tick_s && (os_cnt_q == 4'd9);

  // Tick generator, oversample counter and sample capture
  always_comb begin
    tick_nxt_s = tick_cnt_q;
    os_nxt_s   = os_cnt_q;
    div_d      = div_q;
    samp_d     = samp_q;
    if (active_s) begin
      if (tick_s) begin
        tick_nxt_s = DIV_ZERO;
        div_d      = baud_div;
        os_nxt_s   = os_cnt_q + 4'd1;
        samp_d[0]  = (os_cnt_q == 4'd7) ? rxs_s : samp_q[0];
        samp_d[1]  = (os_cnt_q == 4'd8) ? rxs_s : samp_q[1];
      end else begin
        tick_nxt_s = tick_cnt_q + DIV_ONE;
      end
    end else begin
      tick_nxt_s = DIV_ZERO;
      os_nxt_s   = 4'd0;
      div_d      = baud_div;
    end
  end

  // Deframing FSM: next state, shift register and stop-bit resolution
  always_comb begin
    state_nxt_s = state_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    stop_ok_s   = 1'b0;
    stop_bad_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fall_s) begin
          state_nxt_s = ST_START;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (resolve_s && maj_s) begin
          state_nxt_s = ST_IDLE;
        end else if (tick_s && (os_cnt_q == OS_LAST)) begin
          state_nxt_s = ST_DATA;
          bit_idx_d   = 3'd0;
        end else begin
          state_nxt_s = ST_START;
        end
      end
      ST_DATA: begin
        if (resolve_s) begin
          shift_d = {maj_s, shift_q[7:1]};
        end else if (tick_s && (os_cnt_q == OS_LAST)) begin
          if (bit_idx_q == 3'd7) begin
            state_nxt_s = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      ST_STOP: begin
        if (resolve_s) begin
          state_nxt_s = ST_IDLE;
          stop_ok_s   = maj_s;
          stop_bad_s  = ~maj_s;
        end else begin
          state_nxt_s = ST_STOP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Disabling the receiver abandons any frame in progress
  assign state_d      = rx_en ? state_nxt_s : ST_IDLE;
  assign stop_ok_g_s  = stop_ok_s & rx_en;
  assign stop_bad_g_s = stop_bad_s & rx_en;

  // Counters are always zero whenever the FSM sits in IDLE
  assign tick_cnt_d = (state_d == ST_IDLE) ? DIV_ZERO : tick_nxt_s;
  assign os_cnt_d   = (state_d == ST_IDLE) ? 4'd0 : os_nxt_s;

  // A completing byte wins over a same-cycle read. A new error wins over a clear.
  assign valid_d = stop_ok_g_s ? 1'b1 : (rx_if.rx_ack ? 1'b0 : valid_q);
  assign data_d  = stop_ok_g_s ? shift_q : data_q;
  assign ovr_d   = (stop_ok_g_s && valid_q && !rx_if.rx_ack) ? 1'b1 :
                   (err_clr ? 1'b0 : ovr_q);
  assign ferr_d  = stop_bad_g_s ? 1'b1 : (err_clr ? 1'b0 : ferr_q);
  assign busy_d  = (state_d != ST_IDLE);

  // State and datapath registers with async hard reset and sync soft reset
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      sync_q     <= 2'b11;
      rxs_prev_q <= 1'b1;
      state_q    <= ST_IDLE;
      tick_cnt_q <= DIV_ZERO;
      div_q      <= DIV_ZERO;
      os_cnt_q   <= 4'd0;
      bit_idx_q  <= 3'd0;
      samp_q     <= 2'b11;
      shift_q    <= 8'h00;
      data_q     <= 8'h00;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else if (rx_rst) begin
      sync_q     <= 2'b11;
      rxs_prev_q <= 1'b1;
      state_q    <= ST_IDLE;
      tick_cnt_q <= DIV_ZERO;
      div_q      <= DIV_ZERO;
      os_cnt_q   <= 4'd0;
      bit_idx_q  <= 3'd0;
      samp_q     <= 2'b11;
      shift_q    <= 8'h00;
      data_q     <= 8'h00;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], rx_serial};
      rxs_prev_q <= rxs_s;
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      div_q      <= div_d;
      os_cnt_q   <= os_cnt_d;
      bit_idx_q  <= bit_idx_d;
      samp_q     <= samp_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign rx_if.rx_data  = data_q;
  assign rx_if.rx_valid = valid_q;
  assign rx_busy        = busy_q;
  assign frame_err      = ferr_q;
  assign overrun        = ovr_q;

endmodule

// File: tb/tb_uart_rx_engine.sv
// Scoreboard bench for uart_rx_engine.
// - Stimulus pushes each byte expected in RX_DATA.
// - The monitor pops and compares whenever a new byte is presented.
// - The monitor also generates rx_ack.
module tb_uart_rx_engine;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        rx_en;
  logic        rx_rst;
  logic [15:0] baud_div;
  logic        rx_serial;
  logic        err_clr;
  logic        rx_busy;
  logic        frame_err;
  logic        overrun;

  uart_rx_engine_if rx_if ();

  uart_rx_engine #(.DIV_WIDTH(16), .OS_RATE(16)) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .rx_en     (rx_en),
    .rx_rst    (rx_rst),
    .baud_div  (baud_div),
    .rx_serial (rx_serial),
    .err_clr   (err_clr),
    .rx_busy   (rx_busy),
    .frame_err (frame_err),
    .overrun   (overrun),
    .rx_if     (rx_if.master)
  );

  always #5 PCLK = ~PCLK;

  int         n_checks = 0;
  int         n_fails  = 0;
  logic [7:0] exp_q[$];
  bit         auto_ack = 1'b1;
  int         ack_req_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one bit for bc clock cycles. Called at a falling edge of PCLK.
  task automatic drive_bit(input logic v, input int bc);
    rx_serial = v;
    repeat (bc) @(negedge PCLK);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int bc);
    drive_bit(1'b0, bc);
    for (int i = 0; i < 8; i++) drive_bit(b[i], bc);
    drive_bit(stop, bc);
    rx_serial = 1'b1;
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    @(negedge PCLK);
    err_clr = 1'b0;
    @(negedge PCLK);
  endtask

  // Monitor: compare each newly presented byte against the scoreboard and acknowledge it
  initial begin : monitor
    logic       prev_v;
    logic [7:0] prev_d;
    logic [7:0] exp_b;
    int         ack_done;
    prev_v   = 1'b0;
    prev_d   = 8'h00;
    ack_done = 0;
    rx_if.rx_ack = 1'b0;
    forever begin
      @(negedge PCLK);
      rx_if.rx_ack = 1'b0;
      if (rx_if.rx_valid && (!prev_v || (rx_if.rx_data != prev_d))) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", {24'h0, rx_if.rx_data}, 32'hFFFF_FFFF);
        end else begin
          exp_b = exp_q.pop_front();
          check("sb_rx_data", {24'h0, rx_if.rx_data}, {24'h0, exp_b});
        end
        if (auto_ack) rx_if.rx_ack = 1'b1;
      end
      if (ack_req_cnt != ack_done) begin
        ack_done++;
        rx_if.rx_ack = 1'b1;
      end
      prev_v = rx_if.rx_valid;
      prev_d = rx_if.rx_data;
    end
  end

  // Directed stimulus
  initial begin : stim
    int bc;
    bit saw_busy;
    PRESET    = 1'b1;
    rx_en     = 1'b0;
    rx_rst    = 1'b0;
    baud_div  = 16'd3;
    rx_serial = 1'b1;
    err_clr   = 1'b0;
    bc        = 64;
    repeat (3) @(negedge PCLK);
    check("rst_rx_data",   {24'h0, rx_if.rx_data}, 32'h00);
    check("rst_rx_valid",  {31'h0, rx_if.rx_valid}, 32'h0);
    check("rst_rx_busy",   {31'h0, rx_busy}, 32'h0);
    check("rst_frame_err", {31'h0, frame_err}, 32'h0);
    check("rst_overrun",   {31'h0, overrun}, 32'h0);
    PRESET = 1'b0;
    rx_en  = 1'b1;
    repeat (5) @(negedge PCLK);

    // 1: good byte 0xAF
    exp_q.push_back(8'hAF);
    send_frame(8'hAF, 1'b1, bc);
    repeat (4) @(negedge PCLK);
    check("t1_rx_data",   {24'h0, rx_if.rx_data}, 32'hAF);
    check("t1_frame_err", {31'h0, frame_err}, 32'h0);
    check("t1_overrun",   {31'h0, overrun}, 32'h0);
    check("t1_busy_idle", {31'h0, rx_busy}, 32'h0);

    // 2: short low glitch is rejected as a false start
    saw_busy  = 1'b0;
    rx_serial = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (i == 10) rx_serial = 1'b1;
      @(negedge PCLK);
      saw_busy = saw_busy | rx_busy;
    end
    check("t2_busy_pulsed", {31'h0, saw_busy}, 32'h1);
    check("t2_busy_end",    {31'h0, rx_busy}, 32'h0);
    check("t2_rx_valid",    {31'h0, rx_if.rx_valid}, 32'h0);
    check("t2_rx_data",     {24'h0, rx_if.rx_data}, 32'hAF);

    // 3: stop bit low gives a framing error and leaves the holding register alone
    send_frame(8'h3C, 1'b0, bc);
    repeat (4) @(negedge PCLK);
    check("t3_frame_err", {31'h0, frame_err}, 32'h1);
    check("t3_rx_valid",  {31'h0, rx_if.rx_valid}, 32'h0);
    check("t3_rx_data",   {24'h0, rx_if.rx_data}, 32'hAF);
    pulse_err_clr();
    check("t3_err_clr",   {31'h0, frame_err}, 32'h0);

    // 4: two bytes without a read produce an overrun
    auto_ack = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, bc);
    exp_q.push_back(8'h22);
    send_frame(8'h22, 1'b1, bc);
    repeat (4) @(negedge PCLK);
    check("t4_rx_data",  {24'h0, rx_if.rx_data}, 32'h22);
    check("t4_overrun",  {31'h0, overrun}, 32'h1);
    check("t4_rx_valid", {31'h0, rx_if.rx_valid}, 32'h1);
    ack_req_cnt++;
    repeat (3) @(negedge PCLK);
    check("t4_ack_clears", {31'h0, rx_if.rx_valid}, 32'h0);
    pulse_err_clr();
    check("t4_err_clr",    {31'h0, overrun}, 32'h0);
    auto_ack = 1'b1;

    // 5: baud_div=0, two frames back to back
    baud_div = 16'd0;
    bc       = 16;
    repeat (2) @(negedge PCLK);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'hA5);
    send_frame(8'h5A, 1'b1, bc);
    send_frame(8'hA5, 1'b1, bc);
    repeat (4) @(negedge PCLK);
    check("t5_rx_data",   {24'h0, rx_if.rx_data}, 32'hA5);
    check("t5_frame_err", {31'h0, frame_err}, 32'h0);
    check("t5_overrun",   {31'h0, overrun}, 32'h0);

    // 6a: rx_en dropped during data bit 3
    baud_div = 16'd3;
    bc       = 64;
    repeat (2) @(negedge PCLK);
    fork
      send_frame(8'h96, 1'b1, bc);
      begin
        repeat (4 * 64 + 32) @(negedge PCLK);
        check("t6_busy_before", {31'h0, rx_busy}, 32'h1);
        rx_en = 1'b0;
        @(negedge PCLK);
        check("t6_busy_abort",  {31'h0, rx_busy}, 32'h0);
      end
    join
    repeat (4) @(negedge PCLK);
    check("t6_no_valid",   {31'h0, rx_if.rx_valid}, 32'h0);
    check("t6_data_kept",  {24'h0, rx_if.rx_data}, 32'hA5);
    rx_en = 1'b1;
    repeat (2) @(negedge PCLK);
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, bc);
    repeat (4) @(negedge PCLK);
    check("t6_rx_data",    {24'h0, rx_if.rx_data}, 32'hC3);

    // 6b: PRESET mid-frame aborts at once
    fork
      send_frame(8'h7E, 1'b1, bc);
      begin
        repeat (200) @(negedge PCLK);
        PRESET = 1'b1;
        #1;
        check("t6_rst_busy",  {31'h0, rx_busy}, 32'h0);
        check("t6_rst_data",  {24'h0, rx_if.rx_data}, 32'h00);
        check("t6_rst_valid", {31'h0, rx_if.rx_valid}, 32'h0);
      end
    join
    @(negedge PCLK);
    PRESET = 1'b0;
    repeat (2) @(negedge PCLK);
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, bc);
    repeat (4) @(negedge PCLK);
    check("t6_after_rst", {24'h0, rx_if.rx_data}, 32'hC3);

    // 7: line held low gives one frame error, then no restart while low
    rx_serial = 1'b0;
    repeat (12 * 64) @(negedge PCLK);
    check("t7_frame_err", {31'h0, frame_err}, 32'h1);
    check("t7_busy_low",  {31'h0, rx_busy}, 32'h0);
    check("t7_rx_data",   {24'h0, rx_if.rx_data}, 32'hC3);
    rx_serial = 1'b1;
    repeat (4) @(negedge PCLK);
    pulse_err_clr();
    check("t7_err_clr",   {31'h0, frame_err}, 32'h0);

    // Drain: every pushed byte must have been seen by the monitor
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge PCLK);
    check("sb_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
